apb_arbiter: RTL and testbench

Two-master, one-slave APB arbiter that shares the RAM APB port between the RISC-V core (master 0) and a second bus master such as a DMA or debug agent (master 1). It grants one master per transfer, replays that master's request on the slave-side APB bus, and routes the slave's response back to that master only. A watchdog bounds slave wait states so that a hung slave cannot stall either master forever.

---
 rtl/apb_arbiter.sv | 130 +++++++++++++
 tb/tb_apb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-master to one-slave APB arbiter with slave wait-state watchdog
// Define APB_ARB_RR_EN for round-robin contention; otherwise master 0 has fixed priority.
module apb_arbiter #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_psel,
   input  logic        m0_penable,
   input  logic        m0_pwrite,
   input  logic [31:0] m0_paddr,
   input  logic [31:0] m0_pwdata,
   input  logic [3:0]  m0_pwstrb,
   output logic        m0_pready,
   output logic        m0_pslverr,
   output logic [31:0] m0_prdata,
   input  logic        m1_psel,
   input  logic        m1_penable,
   input  logic        m1_pwrite,
   input  logic [31:0] m1_paddr,
   input  logic [31:0] m1_pwdata,
   input  logic [3:0]  m1_pwstrb,
   output logic        m1_pready,
   output logic        m1_pslverr,
   output logic [31:0] m1_prdata,
   output logic        s_psel,
   output logic        s_penable,
   output logic        s_pwrite,
   output logic [31:0] s_paddr,
   output logic [31:0] s_pwdata,
   output logic [3:0]  s_pwstrb,
   input  logic        s_pready,
   input  logic        s_pslverr,
   input  logic [31:0] s_prdata
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [15:0] TMO = TIMEOUT[15:0];

   state_t      state, state_nxt;
   logic        grant, grant_nxt;
   logic        last_grant, last_grant_nxt;
   logic [15:0] count, count_nxt;
   logic        pick, expired;
   logic        rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic        unused_penable;

   // Masters' penable is not part of the handshake seen by the slave.
   assign unused_penable = m0_penable ^ m1_penable;

`ifdef APB_ARB_RR_EN
   assign pick = (m0_psel && m1_psel) ? ~last_grant : m1_psel;
`else
   assign pick = ~m0_psel;
`endif

   assign expired = (TIMEOUT != 0) && (count == TMO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         count      <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         count      <= count_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      count_nxt      = count;
      s_psel         = 1'b0;
      s_penable      = 1'b0;
      rsp_ready      = 1'b0;
      rsp_err        = 1'b0;
      rsp_data       = '0;
      case (state)
         IDLE: begin
            if (m0_psel || m1_psel) begin
               grant_nxt = pick;
               count_nxt = '0;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            s_psel    = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            s_psel    = 1'b1;
            s_penable = 1'b1;
            if (s_pready) begin
               rsp_ready = 1'b1;
               rsp_err   = s_pslverr;
               rsp_data  = s_prdata;
            end else if (expired) begin
               // Hung slave: complete with an error and no read data.
               rsp_ready = 1'b1;
               rsp_err   = 1'b1;
            end else begin
               count_nxt = count + 16'd1;
            end
            if (rsp_ready) begin
               last_grant_nxt = grant;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign s_pwrite = s_psel & (grant ? m1_pwrite : m0_pwrite);
   assign s_paddr  = s_psel ? (grant ? m1_paddr  : m0_paddr)  : '0;
   assign s_pwdata = s_psel ? (grant ? m1_pwdata : m0_pwdata) : '0;
   assign s_pwstrb = s_psel ? (grant ? m1_pwstrb : m0_pwstrb) : '0;

   assign m0_pready  = rsp_ready & ~grant;
   assign m0_pslverr = rsp_err & ~grant;
   assign m0_prdata  = grant ? '0 : rsp_data;
   assign m1_pready  = rsp_ready & grant;
   assign m1_pslverr = rsp_err & grant;
   assign m1_prdata  = grant ? rsp_data : '0;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - directed and randomized bench for apb_arbiter against a transfer-level model
module tb_apb_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
   logic [31:0] m0_paddr, m0_pwdata, m0_prdata;
   logic [3:0]  m0_pwstrb;
   logic        m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
   logic [31:0] m1_paddr, m1_pwdata, m1_prdata;
   logic [3:0]  m1_pwstrb;
   logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
   logic [31:0] s_paddr, s_pwdata, s_prdata;
   logic [3:0]  s_pwstrb;

   always #5 clk = ~clk;

   apb_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
      .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb),
      .m0_pready(m0_pready), .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
      .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
      .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb),
      .m1_pready(m1_pready), .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
      .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        wr;
   } req_t;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   // transfer-level model state
   req_t q0[$];
   req_t q1[$];
   int   wq[$];
   req_t cur[2];
   bit   active[2];
   bit   viol[2];
   bit   done[2];
   bit   busy = 1'b0;
   bit   own = 1'b0;
   bit   lastg = 1'b1;
   int   gstart = 0;
   int   wplan = 0;
   bit   rand_mode = 1'b0;
   bit   rd_fix_en = 1'b0;
   logic [31:0] rd_fix = '0;
   int   mcount[2];
   int   dcount[2];

   // observations
   int   t_req, t_sel, t_rdy;
   logic [31:0] rdy_data;
   logic rdy_err;
   int   done_log[$];
   logic psel_hist [0:8191];
   int   exp_ord[8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
      req_t r;
      r.addr = a; r.wdata = d; r.strb = s; r.wr = w;
      return r;
   endfunction

   function automatic req_t rand_req();
      return mk_req($urandom(), $urandom(), 4'($urandom_range(15)), $urandom_range(1) != 0);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_s_psel"}, s_psel, 0);
      check({tag, "_s_penable"}, s_penable, 0);
      check({tag, "_s_pwrite"}, s_pwrite, 0);
      check({tag, "_s_paddr"}, s_paddr, 0);
      check({tag, "_s_pwdata"}, s_pwdata, 0);
      check({tag, "_s_pwstrb"}, s_pwstrb, 0);
      check({tag, "_m0_pready"}, m0_pready, 0);
      check({tag, "_m0_pslverr"}, m0_pslverr, 0);
      check({tag, "_m0_prdata"}, m0_prdata, 0);
      check({tag, "_m1_pready"}, m1_pready, 0);
      check({tag, "_m1_pslverr"}, m1_pslverr, 0);
      check({tag, "_m1_prdata"}, m1_prdata, 0);
   endtask

   task automatic mark();
      t_req = -1; t_sel = -1; t_rdy = -1;
      rdy_data = '0; rdy_err = 1'b0;
      done_log.delete();
   endtask

   // One clock cycle: masters update, model arbitrates/predicts, inputs driven, outputs checked at negedge.
   task automatic step();
      bit req0, req1, win, s_rdy, fin, e_sel, e_en, e_err;
      int ph, a;
      logic [31:0] e_addr, e_wdata, e_data;
      logic [3:0]  e_strb;
      logic        e_wr, slv_err;
      logic [31:0] slv_data;
      @(posedge clk);
      #1;
      cyc++;
      for (int m = 0; m < 2; m++) begin
         if (done[m]) begin
            active[m] = 1'b0; viol[m] = 1'b0; done[m] = 1'b0;
         end
         if (!active[m]) begin
            if (m == 0 && q0.size() > 0) begin
               cur[m] = q0.pop_front(); active[m] = 1'b1;
            end else if (m == 1 && q1.size() > 0) begin
               cur[m] = q1.pop_front(); active[m] = 1'b1;
            end else begin
               cur[m] = rand_req();
               if (rand_mode && $urandom_range(2) == 0) active[m] = 1'b1;
            end
            if (active[m] && t_req < 0) t_req = cyc;
         end else if (rand_mode && busy && own == m && $urandom_range(39) == 0) begin
            viol[m] = 1'b1;
         end
      end
      req0 = active[0] && !viol[0];
      req1 = active[1] && !viol[1];
      if (!busy && (req0 || req1)) begin
         if (req0 && req1) begin
`ifdef APB_ARB_RR_EN
            win = !lastg;
`else
            win = 1'b0;
`endif
         end else begin
            win = req1;
         end
         busy = 1'b1; own = win; gstart = cyc;
         if (wq.size() > 0) wplan = wq.pop_front();
         else wplan = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(3));
      end
      ph = busy ? cyc - gstart : 0;
      a = ph - 2;
      s_rdy = (ph >= 2) ? (a == wplan) : ($urandom_range(1) != 0);
      fin = (ph >= 2) && (s_rdy || (TO != 0 && a == TO));
      slv_err = $urandom_range(1) != 0;
      slv_data = rd_fix_en ? rd_fix : $urandom();

      m0_psel = req0; m0_penable = $urandom_range(1) != 0; m0_pwrite = cur[0].wr;
      m0_paddr = cur[0].addr; m0_pwdata = cur[0].wdata; m0_pwstrb = cur[0].strb;
      m1_psel = req1; m1_penable = $urandom_range(1) != 0; m1_pwrite = cur[1].wr;
      m1_paddr = cur[1].addr; m1_pwdata = cur[1].wdata; m1_pwstrb = cur[1].strb;
      s_pready = s_rdy; s_pslverr = slv_err; s_prdata = slv_data;

      e_sel   = ph >= 1;
      e_en    = ph >= 2;
      e_addr  = e_sel ? cur[own].addr  : '0;
      e_wdata = e_sel ? cur[own].wdata : '0;
      e_strb  = e_sel ? cur[own].strb  : '0;
      e_wr    = e_sel ? cur[own].wr    : 1'b0;
      e_err   = fin ? (s_rdy ? slv_err : 1'b1) : 1'b0;
      e_data  = (fin && s_rdy) ? slv_data : '0;
      if (fin) begin
         busy = 1'b0; lastg = own; done[own] = 1'b1; mcount[own]++;
      end

      @(negedge clk);
      check("s_psel", s_psel, e_sel);
      check("s_penable", s_penable, e_en);
      check("s_pwrite", s_pwrite, e_wr);
      check("s_paddr", s_paddr, e_addr);
      check("s_pwdata", s_pwdata, e_wdata);
      check("s_pwstrb", s_pwstrb, e_strb);
      check("m0_pready", m0_pready, fin && own == 0);
      check("m0_pslverr", m0_pslverr, (own == 0) ? e_err : 1'b0);
      check("m0_prdata", m0_prdata, (own == 0) ? e_data : '0);
      check("m1_pready", m1_pready, fin && own == 1);
      check("m1_pslverr", m1_pslverr, (own == 1) ? e_err : 1'b0);
      check("m1_prdata", m1_prdata, (own == 1) ? e_data : '0);

      if (s_psel && t_sel < 0) t_sel = cyc;
      if (cyc < 8192) psel_hist[cyc] = s_psel;
      if (m0_pready) begin
         done_log.push_back(0); dcount[0]++;
         if (t_rdy < 0) begin t_rdy = cyc; rdy_data = m0_prdata; rdy_err = m0_pslverr; end
      end
      if (m1_pready) begin
         done_log.push_back(1); dcount[1]++;
         if (t_rdy < 0) begin t_rdy = cyc; rdy_data = m1_prdata; rdy_err = m1_pslverr; end
      end
   endtask

   task automatic drain(input string tag, input int max);
      int n = 0;
      bit pending;
      do begin
         step();
         n++;
         pending = busy || active[0] || active[1] || q0.size() != 0 || q1.size() != 0;
      end while (pending && n < max);
      check({tag, "_drain_bound"}, pending, 0);
   endtask

   function automatic logic psel_at(input int c);
      return (c >= 0 && c < 8192) ? psel_hist[c] : 1'b1;
   endfunction

   initial begin
      m0_psel = 1'b1; m0_penable = 1'b1; m0_pwrite = 1'b1;
      m0_paddr = 32'hFFFF_FFFF; m0_pwdata = 32'hFFFF_FFFF; m0_pwstrb = 4'hF;
      m1_psel = 1'b1; m1_penable = 1'b1; m1_pwrite = 1'b1;
      m1_paddr = 32'hAAAA_AAAA; m1_pwdata = 32'h5555_5555; m1_pwstrb = 4'hA;
      s_pready = 1'b1; s_pslverr = 1'b1; s_prdata = 32'hCAFE_F00D;
      mark();
      #12;
      check_all_zero("reset");
      m0_psel = 1'b0; m1_psel = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;

      // single zero-wait read from master 0
      mark();
      rd_fix_en = 1'b1; rd_fix = 32'hDEAD_BEEF;
      q0.push_back(mk_req(32'h0000_0010, 32'h0, 4'h0, 1'b0));
      wq.push_back(0);
      drain("rd", 20);
      rd_fix_en = 1'b0;
      check("rd_psel_latency", t_sel - t_req, 1);
      check("rd_pready_latency", t_rdy - t_req, 2);
      check("rd_prdata", rdy_data, 32'hDEAD_BEEF);
      check("rd_count", done_log.size(), 1);

      // master 1 write with three slave wait states
      mark();
      q1.push_back(mk_req(32'h0000_0100, 32'h1234_5678, 4'h3, 1'b1));
      wq.push_back(3);
      drain("wr", 20);
      check("wr_pready_latency", t_rdy - t_req, 5);
      check("wr_count", done_log.size(), 1);
      check("wr_master", done_log[0], 1);

      // contention: four back-to-back transfers from each master
      mark();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rand_req());
         q1.push_back(rand_req());
         wq.push_back(0);
         wq.push_back(0);
      end
`ifdef APB_ARB_RR_EN
      exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      drain("cont", 100);
      check("cont_count", done_log.size(), 8);
      for (int i = 0; i < 8; i++) check("cont_order", done_log[i], exp_ord[i]);

      // watchdog: slave never ready
      mark();
      q0.push_back(mk_req(32'h0000_0020, 32'h0, 4'h0, 1'b0));
      wq.push_back(-1);
      drain("tmo", 30);
      check("tmo_latency", t_rdy - t_req, TO + 2);
      check("tmo_pslverr", rdy_err, 1);
      check("tmo_prdata", rdy_data, 0);
      check("tmo_psel_after", psel_at(t_rdy + 1), 0);
      check("tmo_count", done_log.size(), 1);

      // reset while slave stalls in ACCESS
      mark();
      q0.push_back(rand_req());
      wq.push_back(-1);
      repeat (4) step();
      check("rst_pre_penable", s_penable, 1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      m0_psel = 1'b0; m1_psel = 1'b0;
      busy = 1'b0; lastg = 1'b1;
      for (int m = 0; m < 2; m++) begin
         active[m] = 1'b0; viol[m] = 1'b0; done[m] = 1'b0;
      end
      q0.delete(); q1.delete(); wq.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      mark();
      q1.push_back(rand_req());
      wq.push_back(0);
      drain("post_rst", 20);
      check("post_rst_latency", t_rdy - t_req, 2);
      check("post_rst_count", done_log.size(), 1);
      check("post_rst_master", done_log[0], 1);

      // randomized traffic
      mark();
      rand_mode = 1'b1;
      repeat (2000) step();
      rand_mode = 1'b0;
      drain("rand", 100);
      check("m0_transfers", dcount[0], mcount[0]);
      check("m1_transfers", dcount[1], mcount[1]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
